// File: rtl/pong_pkg.sv
// Shared Pong display definitions: VGA 640x480@60 timing, the RGB pixel type and colours.
package pong_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t COLOR_WHITE = 12'hFFF;
    localparam rgb_t COLOR_BLACK = 12'h000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster h/v counters with raw (unpipelined) active-low sync and visible-region flags.
module vga_timing
    import pong_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
    localparam int HCW      = $clog2(H_TOTAL),
    localparam int VCW      = $clog2(V_TOTAL)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           pix_en_i,
    output logic [HCW-1:0] h_cnt_o,
    output logic [VCW-1:0] v_cnt_o,
    output logic           hsync_o,
    output logic           vsync_o,
    output logic           vis_o
);

    logic [HCW-1:0] h_cnt_q, h_cnt_d;
    logic [VCW-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en_i) begin
            if (h_cnt_q == HCW'(H_TOTAL - 1)) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == VCW'(V_TOTAL - 1)) ? '0 : v_cnt_q + VCW'(1);
            end else begin
                h_cnt_d = h_cnt_q + HCW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt_o = h_cnt_q;
    assign v_cnt_o = v_cnt_q;
    assign vis_o   = (h_cnt_q < HCW'(H_VISIBLE)) && (v_cnt_q < VCW'(V_VISIBLE));
    assign hsync_o = !((h_cnt_q >= HCW'(H_VISIBLE + H_FRONT)) &&
                       (h_cnt_q <  HCW'(H_VISIBLE + H_FRONT + H_SYNC)));
    assign vsync_o = !((v_cnt_q >= VCW'(V_VISIBLE + V_FRONT)) &&
                       (v_cnt_q <  VCW'(V_VISIBLE + V_FRONT + V_SYNC)));

endmodule

// File: rtl/frame_renderer.sv
// Pong frame renderer: per-frame position snapshot, two-stage pixel pipeline, aligned syncs.
// Optional dashed centre net enabled by defining FRAME_RENDERER_CENTER_LINE_EN.
module frame_renderer
    import pong_pkg::*;
#(
    parameter int          H_VISIBLE      = VGA_H_VISIBLE,
    parameter int          H_FRONT        = VGA_H_FRONT,
    parameter int          H_SYNC         = VGA_H_SYNC,
    parameter int          H_BACK         = VGA_H_BACK,
    parameter int          V_VISIBLE      = VGA_V_VISIBLE,
    parameter int          V_FRONT        = VGA_V_FRONT,
    parameter int          V_SYNC         = VGA_V_SYNC,
    parameter int          V_BACK         = VGA_V_BACK,
    parameter int          PADDLE_1_X     = 16,
    parameter int          PADDLE_2_X     = 616,
    parameter int          PADDLE_WIDTH   = 8,
    parameter int          PADDLE_HEIGHT  = 64,
    parameter int          BALL_SIDE_SIZE = 8,
    parameter logic [11:0] FG_COLOR       = COLOR_WHITE,
    parameter logic [11:0] BG_COLOR       = COLOR_BLACK,
    localparam int         H_TOTAL        = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
    localparam int         V_TOTAL        = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
    localparam int         PW             = $clog2(V_VISIBLE + 1) + 1,
    localparam int         XW             = $clog2(H_VISIBLE + 1) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    input  logic [PW-1:0] paddle_1_pos,
    input  logic [PW-1:0] paddle_2_pos,
    input  logic [XW-1:0] ball_pos_x,
    input  logic [PW-1:0] ball_pos_y,
    output logic          hsync,
    output logic          vsync,
    output logic [11:0]   rgb,
    output logic          video_active,
    output logic          frame_start
);

    localparam int HCW = $clog2(H_TOTAL);
    localparam int VCW = $clog2(V_TOTAL);
    // One spare bit above every operand so lo+len never wraps.
    localparam int CW  = max2(max2(XW, PW), max2(HCW, VCW)) + 1;

    function automatic logic in_span(input logic [CW-1:0] v,
                                     input logic [CW-1:0] lo,
                                     input logic [CW-1:0] len);
        return (v >= lo) && (v < lo + len);
    endfunction

    logic [HCW-1:0] h_cnt;
    logic [VCW-1:0] v_cnt;
    logic           hs_raw, vs_raw, vis_raw;

    vga_timing #(
        .H_VISIBLE (H_VISIBLE), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
        .V_VISIBLE (V_VISIBLE), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK)
    ) u_timing (
        .clk_i    (clk),
        .rst_i    (rst),
        .pix_en_i (pix_en),
        .h_cnt_o  (h_cnt),
        .v_cnt_o  (v_cnt),
        .hsync_o  (hs_raw),
        .vsync_o  (vs_raw),
        .vis_o    (vis_raw)
    );

    // Snapshot at the first blanking line so a frame never mixes old and new positions.
    logic          snap_take;
    logic [PW-1:0] snap_pad1_q, snap_pad2_q, snap_by_q;
    logic [XW-1:0] snap_bx_q;
    logic          frame_start_q;

    assign snap_take = pix_en && (h_cnt == '0) && (v_cnt == VCW'(V_VISIBLE));

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_pad1_q   <= '0;
            snap_pad2_q   <= '0;
            snap_bx_q     <= '0;
            snap_by_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= snap_take;
            if (snap_take) begin
                snap_pad1_q <= paddle_1_pos;
                snap_pad2_q <= paddle_2_pos;
                snap_bx_q   <= ball_pos_x;
                snap_by_q   <= ball_pos_y;
            end
        end
    end

    // ---- stage p1: region, sync and hit flags from the raw raster position
    logic [CW-1:0] x_ext, y_ext;
    logic          hit_pad1_d, hit_pad2_d, hit_ball_d;
    logic          vld_p1_q, vis_p1_q, hs_p1_q, vs_p1_q;
    logic          hit_pad1_p1_q, hit_pad2_p1_q, hit_ball_p1_q;

    assign x_ext = CW'(h_cnt);
    assign y_ext = CW'(v_cnt);

    assign hit_pad1_d = in_span(x_ext, CW'(PADDLE_1_X), CW'(PADDLE_WIDTH)) &&
                        in_span(y_ext, CW'(snap_pad1_q), CW'(PADDLE_HEIGHT));
    assign hit_pad2_d = in_span(x_ext, CW'(PADDLE_2_X), CW'(PADDLE_WIDTH)) &&
                        in_span(y_ext, CW'(snap_pad2_q), CW'(PADDLE_HEIGHT));
    assign hit_ball_d = in_span(x_ext, CW'(snap_bx_q), CW'(BALL_SIDE_SIZE)) &&
                        in_span(y_ext, CW'(snap_by_q), CW'(BALL_SIDE_SIZE));

`ifdef FRAME_RENDERER_CENTER_LINE_EN
    logic hit_net_d, hit_net_p1_q;
    assign hit_net_d = in_span(x_ext, CW'(H_VISIBLE / 2 - 1), CW'(2)) && !v_cnt[3];

    always_ff @(posedge clk) begin
        if (pix_en) hit_net_p1_q <= hit_net_d;
    end
`endif

    // ---- stage p2: colour resolve and sync alignment
    logic vld_p2_q, vis_p2_q, hs_p2_q, vs_p2_q;
    logic fg_p1;
    rgb_t rgb_d, rgb_p2_q;

    always_comb begin
        fg_p1 = hit_ball_p1_q | hit_pad1_p1_q | hit_pad2_p1_q;
`ifdef FRAME_RENDERER_CENTER_LINE_EN
        fg_p1 = fg_p1 | hit_net_p1_q;
`endif
        rgb_d = '0;
        if (vis_p1_q) rgb_d = fg_p1 ? FG_COLOR : BG_COLOR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else if (pix_en) begin
            vld_p1_q <= 1'b1;
            vld_p2_q <= vld_p1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (pix_en) begin
            vis_p1_q      <= vis_raw;
            hs_p1_q       <= hs_raw;
            vs_p1_q       <= vs_raw;
            hit_pad1_p1_q <= hit_pad1_d;
            hit_pad2_p1_q <= hit_pad2_d;
            hit_ball_p1_q <= hit_ball_d;
            vis_p2_q      <= vis_p1_q;
            hs_p2_q       <= hs_p1_q;
            vs_p2_q       <= vs_p1_q;
            rgb_p2_q      <= rgb_d;
        end
    end

    // Until the pipeline refills after reset the outputs sit at their idle levels.
    assign hsync        = ~vld_p2_q | hs_p2_q;
    assign vsync        = ~vld_p2_q | vs_p2_q;
    assign video_active = vld_p2_q & vis_p2_q;
    assign rgb          = vld_p2_q ? rgb_p2_q : '0;
    assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_frame_renderer.sv
// Directed bench for frame_renderer on a scaled-down raster (64x39 total, 48x32 visible).
module tb_frame_renderer;

    localparam int HV = 48, HF = 4, HS = 8, HB = 4;
    localparam int VV = 32, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int P1X = 4, P2X = 40, PWD = 4, PHT = 8, BSZ = 4;
    localparam int PW = $clog2(VV + 1) + 1;
    localparam int XW = $clog2(HV + 1) + 1;

    logic          clk = 1'b0;
    logic          rst, pix_en;
    logic [PW-1:0] p1, p2, by;
    logic [XW-1:0] bx;
    logic          hsync, vsync, video_active, frame_start;
    logic [11:0]   rgb;

    always #5 clk = ~clk;

    frame_renderer #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .PADDLE_1_X (P1X), .PADDLE_2_X (P2X), .PADDLE_WIDTH (PWD),
        .PADDLE_HEIGHT (PHT), .BALL_SIDE_SIZE (BSZ),
        .FG_COLOR (12'hFFF), .BG_COLOR (12'h000)
    ) dut (
        .clk (clk), .rst (rst), .pix_en (pix_en),
        .paddle_1_pos (p1), .paddle_2_pos (p2),
        .ball_pos_x (bx), .ball_pos_y (by),
        .hsync (hsync), .vsync (vsync), .rgb (rgb),
        .video_active (video_active), .frame_start (frame_start)
    );

    int checks = 0, errors = 0;
    int n, clk_no = 0;
    int s_p1, s_p2, s_bx, s_by;
    int mism_px, mism_fs, fs_total, fs_wide, gap_bad, exp_gap, last_fs_clk;
    bit prev_fs;
    int fg_cnt[4], fg_sumx[4], hs_low[4], vs_low[4];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input int v, input int lo, input int len);
        return (v >= lo) && (v < lo + len);
    endfunction

    // {hsync, vsync, video_active, rgb} expected for raster pixel index p
    function automatic logic [14:0] exp_pixel(input int p);
        int x = p % HT;
        int y = (p / HT) % VT;
        bit va = (x < HV) && (y < VV);
        bit hs = !((x >= HV + HF) && (x < HV + HF + HS));
        bit vs = !((y >= VV + VF) && (y < VV + VF + VS));
        bit fg = (in_rng(x, P1X, PWD) && in_rng(y, s_p1, PHT)) ||
                 (in_rng(x, P2X, PWD) && in_rng(y, s_p2, PHT)) ||
                 (in_rng(x, s_bx, BSZ) && in_rng(y, s_by, BSZ));
        logic [11:0] c = va ? (fg ? 12'hFFF : 12'h000) : 12'h000;
        return {hs, vs, va, c};
    endfunction

    task automatic clear_stats();
        mism_px = 0; mism_fs = 0; fs_total = 0; fs_wide = 0; gap_bad = 0;
        last_fs_clk = -1; prev_fs = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fg_cnt[i] = 0; fg_sumx[i] = 0; hs_low[i] = 0; vs_low[i] = 0;
        end
    endtask

    task automatic step(input bit en);
        logic [14:0] e;
        bit          fs_exp;
        int          f;
        pix_en = en;
        @(posedge clk);
        clk_no++;
        fs_exp = 1'b0;
        if (en) begin
            n++;
            if ((n - 1) % FT == VV * HT) begin
                fs_exp = 1'b1;
                s_p1 = int'(p1); s_p2 = int'(p2); s_bx = int'(bx); s_by = int'(by);
            end
        end
        @(negedge clk);
        e = (n >= 2) ? exp_pixel(n - 2) : 15'b110_0000_0000_0000;
        if ({hsync, vsync, video_active, rgb} !== e) mism_px++;
        if (frame_start !== fs_exp) mism_fs++;
        if (en && n >= 2) begin
            f = (n - 2) / FT;
            if (f < 4) begin
                if (rgb == 12'hFFF) begin
                    fg_cnt[f]++;
                    fg_sumx[f] += (n - 2) % HT;
                end
                if (!hsync) hs_low[f]++;
                if (!vsync) vs_low[f]++;
            end
        end
        if (frame_start) begin
            fs_total++;
            if (last_fs_clk >= 0 && clk_no - last_fs_clk != exp_gap) gap_bad++;
            if (prev_fs) fs_wide++;
            last_fs_clk = clk_no;
        end
        prev_fs = frame_start;
    endtask

    task automatic do_reset();
        rst = 1'b1; pix_en = 1'b1;
        @(posedge clk);
        clk_no++;
        @(negedge clk);
        check("rst_hsync", int'(hsync), 1);
        check("rst_vsync", int'(vsync), 1);
        check("rst_rgb", int'(rgb), 0);
        check("rst_video_active", int'(video_active), 0);
        check("rst_frame_start", int'(frame_start), 0);
        rst = 1'b0;
        n = 0; s_p1 = 0; s_p2 = 0; s_bx = 0; s_by = 0;
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b0;
        p1 = PW'(5); p2 = PW'(12); bx = XW'(20); by = PW'(10);

        // Continuous pix_en, ball moves from x=20 to x=30 on line 10 of frame 1
        do_reset();
        clear_stats(); exp_gap = FT;
        repeat (FT + 10 * HT) step(1'b1);
        bx = XW'(30);
        repeat (2 * FT - 10 * HT + 2) step(1'b1);
        check("run_pixels", mism_px, 0);
        check("run_frame_start", mism_fs, 0);
        check("run_f0_fg_count", fg_cnt[0], 80);
        check("run_f0_fg_sumx", fg_sumx[0], 1528);
        check("run_f1_fg_count", fg_cnt[1], 80);
        check("run_f1_fg_sumx", fg_sumx[1], 1848);
        check("run_f2_fg_sumx", fg_sumx[2], 2008);
        check("run_hsync_low", hs_low[0], 8 * VT);
        check("run_vsync_low", vs_low[0], 2 * HT);
        check("run_fs_pulses", fs_total, 3);
        check("run_fs_period", gap_bad, 0);
        check("run_fs_width", fs_wide, 0);

        // pix_en toggling every clock
        p1 = PW'(5); p2 = PW'(12); bx = XW'(20); by = PW'(10);
        do_reset();
        clear_stats(); exp_gap = 2 * FT;
        repeat (2 * FT + 2) begin
            step(1'b1);
            step(1'b0);
        end
        check("tog_pixels", mism_px, 0);
        check("tog_frame_start", mism_fs, 0);
        check("tog_f0_fg_sumx", fg_sumx[0], 1528);
        check("tog_f1_fg_sumx", fg_sumx[1], 1848);
        check("tog_hsync_low", hs_low[0], 8 * VT);
        check("tog_fs_pulses", fs_total, 2);
        check("tog_fs_period", gap_bad, 0);
        check("tog_fs_width", fs_wide, 0);

        // Clipped ball at the bottom-right corner, paddle at line 0, then mid-frame reset
        p1 = PW'(0); p2 = PW'(20); bx = XW'(46); by = PW'(30);
        do_reset();
        clear_stats(); exp_gap = FT;
        repeat (2 * FT + 20 * HT + 5) step(1'b1);
        check("edge_pixels", mism_px, 0);
        check("edge_frame_start", mism_fs, 0);
        check("edge_f1_fg_count", fg_cnt[1], 68);
        check("edge_f1_fg_sumx", fg_sumx[1], 1690);
        do_reset();
        clear_stats();
        repeat (VV * HT + 4) step(1'b1);
        check("rst_mid_pixels", mism_px, 0);
        check("rst_mid_frame_start", mism_fs, 0);
        check("rst_mid_fg_count", fg_cnt[0], 80);
        check("rst_mid_fg_sumx", fg_sumx[0], 1528);
        check("rst_mid_fs_pulses", fs_total, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
